display_sampler: RTL and testbench
==================================

# display_sampler

Multi-channel, parametrised sample-and-hold that throttles fast ADC data down to a human-readable refresh rate for the 7-segment/display path. A free-running prescaler generates an update tick. On each tick, every channel's output register loads a value according to the selected mode: last sample, block average, or peak since the previous update. The block sits between the ADC capture logic and the display driver.

## Interface
- `CH`, 4: number of channels.
- `W`, 16: sample width per channel (unsigned).
- `PERIOD`, 1000000: clock cycles between update ticks (≥2); gives 1 Hz at 1 MHz.
- `AVG_LOG2`, 4: average block length is 2^AVG_LOG2 valid samples (1..8).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mode`  in  2  00 SNAP, 01 AVG, 10 PEAK, 11 reserved (behaves as SNAP).
- `hold`  in  1  freeze display outputs while high.
- `in_valid`  in  1  `data_in` carries a new sample set this cycle.
- `data_in`  in  CH*W  channel k at bits [k*W +: W].
- `data_out`  out  CH*W  displayed values, same packing.
- `upd_stb`  out  1  one-cycle pulse when `data_out` was just reloaded.

## Operation
- Tick counter runs 0..PERIOD-1 and wraps to 0. `tick` is asserted combinationally when the count equals PERIOD-1. The counter is never stopped by `hold` or `mode`.
- Per channel, per valid sample:
  - **last**: `last` register loads the sample.
  - **AVG**: accumulator (W+AVG_LOG2 bits, cannot overflow) adds the sample; a sample count runs 0..2^AVG_LOG2-1. When the final sample of a block arrives, `avg` ← (acc + sample) >> AVG_LOG2 (truncating), and acc/count clear.
  - **PEAK**: `peak` ← max(peak, sample); `seen` ← 1.
- On tick with `hold`=0, `data_out` loads according to `mode`:
  - **SNAP**: `data_in` if `in_valid` on that cycle, else `last`.
  - **AVG**: `avg` as registered before the tick edge; a block completing on the tick cycle is shown at the next tick.
  - **PEAK**: max(peak, same-cycle valid sample). If `seen`=0 and no same-cycle sample, `data_out` is unchanged but `upd_stb` still pulses. Then `peak` and `seen` clear; the tick-cycle sample belongs to the closing window.
- On tick with `hold`=1: no `data_out` change, no `upd_stb`. The PEAK window still closes and clears; AVG/last tracking continues.
- Mode change: `mode` is registered internally. In the cycle after a change, acc, sample count, `peak` and `seen` clear (any sample in that cycle is discarded). `avg` and `last` keep their values.
- Reset: counter, last, acc, count, avg, peak and seen are 0; `data_out` = 0; `upd_stb` = 0. All state is asynchronously cleared mid-operation; the counter restarts at 0.

## Timing
- `data_out` and `upd_stb` are registered and update on the clock edge ending the tick cycle. Latency is 1 cycle from tick to output.
- First update after reset release: `upd_stb` high in cycle PERIOD (counting the first active cycle as 0). Subsequent pulses every PERIOD cycles.
- SNAP end-to-end: a sample presented in the tick cycle appears on `data_out` 1 cycle later.
- AVG: the output trails the block's last sample by at most one PERIOD plus 1 cycle.
- `in_valid` may be high every cycle. There is no backpressure and no sample is ever stalled.

## Structure
- `display_sampler_pkg`: mode encodings (SNAP/AVG/PEAK) and the default-parameter localparams.
- Sub-module `sampler_channel` holds one channel's last/acc/count/avg/peak/seen registers and output mux. It is instantiated CH times via generate. The top holds the tick counter, mode register/change detect, `hold` gating, `upd_stb`, and output packing.

## Test plan
- **Reset/first tick.** PERIOD=8, SNAP, constant `data_in` ch0=0x1234. Required: `data_out`=0 until cycle 8, then `upd_stb` pulses and ch0=0x1234.
- **AVG.** AVG_LOG2=2, samples 10, 11, 12, 14 on ch1. Required: next tick shows 11 (47>>2). A 5th sample alone does not change the shown value.
- **PEAK window.** Samples 5, 0xFFFF, 3 in window 1; window 2 has 7 on the tick cycle only. Required: outputs 0xFFFF, then 7. A following empty window leaves 7 shown and `upd_stb` still pulses.
- **Hold.** Assert `hold` across two ticks in SNAP while the input changes 1→2. Required: output unchanged, no `upd_stb`. After release, the next tick shows 2.
- **Mode switch + async reset.** Switch AVG→PEAK mid-block, then pull `rst` low mid-period. Required: partial block discarded (no stale average), outputs 0 immediately, tick phase restarts from 0.

Source files
------------

// File: rtl/display_sampler_pkg.sv
// Shared definitions for the display sampler: mode encodings and default parameters.
package display_sampler_pkg;

  typedef enum logic [1:0] {
    MODE_SNAP = 2'b00,
    MODE_AVG  = 2'b01,
    MODE_PEAK = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  localparam int DEF_CH       = 4;
  localparam int DEF_W        = 16;
  localparam int DEF_PERIOD   = 1000000;
  localparam int DEF_AVG_LOG2 = 4;

endpackage

// File: rtl/sampler_channel.sv
// One channel of the display sampler: last/average/peak trackers and the value
// offered to the display register on an update tick.
module sampler_channel
  import display_sampler_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] sample,
  input  mode_e        mode,
  input  logic         clr,
  input  logic         tick,
  output logic [W-1:0] sel_val,
  output logic         sel_ok
);

  localparam int AW = W + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;

  logic [W-1:0]        last_q;
  logic [W-1:0]        avg_q;
  logic [W-1:0]        peak_q;
  logic [AW-1:0]       acc_q;
  logic [AVG_LOG2-1:0] cnt_q;
  logic                seen_q;

  logic [AW-1:0] acc_sum;
  logic [W-1:0]  peak_now;

  assign acc_sum  = acc_q + AW'(sample);
  assign peak_now = (in_valid && sample > peak_q) ? sample : peak_q;

  // NOTE: every tracker is a handful of flops, so all of it is cleared by the
  // async reset; state registers use non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= '0;
      avg_q  <= '0;
      peak_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      if (in_valid) last_q <= sample;

      if (clr) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (in_valid) begin
        if (cnt_q == CNT_LAST) begin
          avg_q <= acc_sum[AW-1:AVG_LOG2];
          acc_q <= '0;
          cnt_q <= '0;
        end else begin
          acc_q <= acc_sum;
          cnt_q <= cnt_q + AVG_LOG2'(1);
        end
      end

      // The tick-cycle sample was already folded into peak_now for the closing window.
      if (clr || tick) begin
        peak_q <= '0;
        seen_q <= 1'b0;
      end else if (in_valid) begin
        peak_q <= peak_now;
        seen_q <= 1'b1;
      end
    end
  end

  // NOTE: outputs get defaults before the case so no path can infer a latch.
  always_comb begin
    sel_val = in_valid ? sample : last_q;
    sel_ok  = 1'b1;
    case (mode)
      MODE_AVG:  sel_val = avg_q;
      MODE_PEAK: begin
        sel_val = peak_now;
        sel_ok  = seen_q | in_valid;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/display_sampler.sv
// Multi-channel sample-and-hold that refreshes display values once per PERIOD
// cycles from the last, block-averaged or peak ADC sample.
module display_sampler
  import display_sampler_pkg::*;
#(
  parameter int CH       = DEF_CH,
  parameter int W        = DEF_W,
  parameter int PERIOD   = DEF_PERIOD,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mode,
  input  logic            hold,
  input  logic            in_valid,
  input  logic [CH*W-1:0] data_in,
  output logic [CH*W-1:0] data_out,
  output logic            upd_stb
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q;
  mode_e         mode_q;
  mode_e         mode_in;
  logic          tick;
  logic          clr;
  logic          load;

  logic [W-1:0]  sel_val [CH];
  logic [CH-1:0] sel_ok;
  logic [W-1:0]  out_q   [CH];

  assign mode_in = mode_e'(mode);
  assign tick    = (cnt_q == CNT_MAX);
  assign clr     = (mode_in != mode_q);
  assign load    = tick & ~hold;

  // Free-running prescaler; neither hold nor mode ever stalls it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      mode_q  <= MODE_SNAP;
      upd_stb <= 1'b0;
    end else begin
      cnt_q   <= tick ? '0 : cnt_q + CW'(1);
      mode_q  <= mode_in;
      upd_stb <= load;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    sampler_channel #(
      .W        (W),
      .AVG_LOG2 (AVG_LOG2)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .sample   (data_in[g*W +: W]),
      .mode     (mode_q),
      .clr      (clr),
      .tick     (tick),
      .sel_val  (sel_val[g]),
      .sel_ok   (sel_ok[g])
    );
  end

  // A PEAK window with no samples keeps the old value yet still strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < CH; k++) out_q[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < CH; k++) begin
        if (sel_ok[k]) out_q[k] <= sel_val[k];
      end
    end
  end

  always_comb begin
    data_out = '0;
    for (int k = 0; k < CH; k++) data_out[k*W +: W] = out_q[k];
  end

endmodule

// File: tb/tb_display_sampler.sv
// Self-checking bench for display_sampler: directed windows from a table,
// hand-written mode-switch/reset sequences and randomized traffic vs a queue model.
module tb_display_sampler;

  localparam int CH       = 4;
  localparam int W        = 16;
  localparam int PERIOD   = 8;
  localparam int AVG_LOG2 = 2;
  localparam int BLK      = 2 ** AVG_LOG2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic            hold = 1'b0;
  logic            in_valid = 1'b0;
  logic [CH*W-1:0] data_in = '0;
  logic [CH*W-1:0] data_out;
  logic            upd_stb;

  display_sampler #(
    .CH       (CH),
    .W        (W),
    .PERIOD   (PERIOD),
    .AVG_LOG2 (AVG_LOG2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .hold     (hold),
    .in_valid (in_valid),
    .data_in  (data_in),
    .data_out (data_out),
    .upd_stb  (upd_stb)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model: sample lists per averaging block and per peak window.
  logic [W-1:0] m_last [CH];
  logic [W-1:0] m_avg  [CH];
  logic [W-1:0] m_out  [CH];
  logic         m_stb;
  logic [1:0]   m_mode;
  int           m_phase;
  int unsigned  blk [CH][$];
  int unsigned  win [CH][$];

  typedef struct {
    string       name;
    logic [1:0]  md;
    logic        hd;
    logic [7:0]  vm;
    logic [7:0][15:0] smp;
    logic [15:0] exp_val;
    logic        exp_stb;
  } win_t;

  win_t tbl [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_last[k] = '0;
      m_avg[k]  = '0;
      m_out[k]  = '0;
      blk[k].delete();
      win[k].delete();
    end
    m_stb   = 1'b0;
    m_mode  = 2'd0;
    m_phase = 0;
  endtask

  task automatic model_step(input logic v, input logic [CH*W-1:0] d,
                            input logic [1:0] md, input logic hd);
    bit tk;
    bit chg;
    tk    = (m_phase == PERIOD - 1);
    chg   = (md != m_mode);
    m_stb = tk && !hd;
    for (int k = 0; k < CH; k++) begin
      int unsigned s;
      int unsigned best;
      int unsigned sum;
      bit any;
      s = int'(d[k*W +: W]);
      if (m_stb) begin
        case (m_mode)
          2'd1: m_out[k] = m_avg[k];
          2'd2: begin
            best = 0;
            any  = 1'b0;
            for (int i = 0; i < win[k].size(); i++) begin
              any = 1'b1;
              if (win[k][i] > best) best = win[k][i];
            end
            if (v) begin
              any = 1'b1;
              if (s > best) best = s;
            end
            if (any) m_out[k] = W'(best);
          end
          default: m_out[k] = v ? W'(s) : m_last[k];
        endcase
      end
      if (v) m_last[k] = W'(s);
      if (chg) blk[k].delete();
      else if (v) begin
        blk[k].push_back(s);
        if (blk[k].size() == BLK) begin
          sum = 0;
          for (int i = 0; i < BLK; i++) sum += blk[k][i];
          m_avg[k] = W'(sum / BLK);
          blk[k].delete();
        end
      end
      if (chg || tk) win[k].delete();
      else if (v) win[k].push_back(s);
    end
    m_mode  = md;
    m_phase = (m_phase + 1) % PERIOD;
  endtask

  // Drive one cycle, advance the model, and compare just after the edge.
  task automatic cycle(input logic v, input logic [CH*W-1:0] d,
                       input logic [1:0] md, input logic hd);
    logic [CH*W-1:0] exp_d;
    in_valid = v;
    data_in  = d;
    mode     = md;
    hold     = hd;
    model_step(v, d, md, hd);
    @(posedge clk);
    #1;
    for (int k = 0; k < CH; k++) exp_d[k*W +: W] = m_out[k];
    check("model data_out", data_out, exp_d);
    check("model upd_stb", {63'd0, upd_stb}, {63'd0, m_stb});
  endtask

  function automatic win_t mk(input string name, input logic [1:0] md, input logic hd,
                              input logic [7:0] vm, input logic [127:0] smp,
                              input logic [15:0] exp_val, input logic exp_stb);
    win_t r;
    r.name    = name;
    r.md      = md;
    r.hd      = hd;
    r.vm      = vm;
    r.smp     = smp;
    r.exp_val = exp_val;
    r.exp_stb = exp_stb;
    return r;
  endfunction

  initial begin
    int first;
    logic [1:0]      cur_mode;
    logic            cur_hold;
    logic [CH*W-1:0] d;

    // Each row is one full PERIOD window on channel 1; expectation is read at its tick.
    tbl[0] = mk("avg block",       2'd1, 1'b0, 8'b0001_1110,
                {16'd0, 16'd0, 16'd0, 16'd14, 16'd12, 16'd11, 16'd10, 16'd0}, 16'd11, 1'b1);
    tbl[1] = mk("avg partial",     2'd1, 1'b0, 8'b0000_0010,
                {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd100, 16'd0}, 16'd11, 1'b1);
    tbl[2] = mk("peak window",     2'd2, 1'b0, 8'b0001_1100,
                {16'd0, 16'd0, 16'd0, 16'd3, 16'hFFFF, 16'd5, 16'd0, 16'd0}, 16'hFFFF, 1'b1);
    tbl[3] = mk("peak tick only",  2'd2, 1'b0, 8'b1000_0000,
                {16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 16'd7, 1'b1);
    tbl[4] = mk("peak empty",      2'd2, 1'b0, 8'b0000_0000, 128'd0, 16'd7, 1'b1);
    tbl[5] = mk("snap one",        2'd0, 1'b0, 8'hFF, {8{16'd1}}, 16'd1, 1'b1);
    tbl[6] = mk("hold tick a",     2'd0, 1'b1, 8'hFF, {8{16'd2}}, 16'd1, 1'b0);
    tbl[7] = mk("hold tick b",     2'd0, 1'b1, 8'hFF, {8{16'd2}}, 16'd1, 1'b0);
    tbl[8] = mk("release shows 2", 2'd0, 1'b0, 8'h00, 128'd0, 16'd2, 1'b1);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset data_out", data_out, 64'd0);
    check("reset upd_stb", {63'd0, upd_stb}, 64'd0);
    rst = 1'b1;

    // First update after reset lands in cycle PERIOD.
    for (int c = 0; c < PERIOD; c++) begin
      cycle(1'b1, 64'h1234, 2'd0, 1'b0);
      if (c < PERIOD - 1) check("pre-tick stb low", {63'd0, upd_stb}, 64'd0);
    end
    check("first tick stb", {63'd0, upd_stb}, 64'd1);
    check("first tick ch0", {48'd0, data_out[15:0]}, 64'h1234);

    for (int t = 0; t < 9; t++) begin
      for (int c = 0; c < PERIOD; c++)
        cycle(tbl[t].vm[c], {32'd0, tbl[t].smp[c], 16'd0}, tbl[t].md, tbl[t].hd);
      check({tbl[t].name, " ch1"}, {48'd0, data_out[31:16]}, {48'd0, tbl[t].exp_val});
      check({tbl[t].name, " stb"}, {63'd0, upd_stb}, {63'd0, tbl[t].exp_stb});
    end

    // AVG -> PEAK mid-block: the two ch2 samples must not leak into a later average.
    cycle(1'b0, 64'd0, 2'd1, 1'b0);
    cycle(1'b1, 64'd50 << 32, 2'd1, 1'b0);
    cycle(1'b1, 64'd60 << 32, 2'd1, 1'b0);
    for (int c = 3; c < PERIOD; c++) cycle(1'b0, 64'd0, 2'd2, 1'b0);
    check("empty peak after switch stb", {63'd0, upd_stb}, 64'd1);
    cycle(1'b0, 64'd0, 2'd1, 1'b0);
    cycle(1'b1, 64'd70 << 32, 2'd1, 1'b0);
    cycle(1'b1, 64'd80 << 32, 2'd1, 1'b0);
    for (int c = 3; c < PERIOD; c++) cycle(1'b0, 64'd0, 2'd1, 1'b0);
    check("no stale average ch2", {48'd0, data_out[47:32]}, 64'd0);

    // Asynchronous reset in the middle of a period.
    for (int c = 0; c < 3; c++) cycle(1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 2'd0, 1'b0);
    rst = 1'b0;
    model_reset();
    #1;
    check("async reset data_out", data_out, 64'd0);
    check("async reset upd_stb", {63'd0, upd_stb}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    first = -1;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      cycle(1'b1, {$urandom, $urandom}, 2'd0, 1'b0);
      if (upd_stb) begin
        first = i;
        break;
      end
    end
    check("tick phase after reset", 64'(first), 64'(PERIOD - 1));

    // Randomized traffic, compared every cycle against the model.
    cur_mode = 2'd0;
    cur_hold = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) cur_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) cur_hold = ~cur_hold;
      d = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) d = '1;
      cycle(1'($urandom_range(0, 1)), d, cur_mode, cur_hold);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
